// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU engine feeding the HI/LO register.
// Optional build macro: MULT_DIV_DIV0_FLAG_EN (md_div_zero output, divide-by-zero fast path).

package mult_div_pkg;
  localparam int unsigned DATA_32_W = 32;
  localparam int unsigned ACC_W     = 2 * DATA_32_W;
  localparam int unsigned CNT_W     = $clog2(DATA_32_W);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
endpackage

module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 md_start,
  input  logic [1:0]           md_op,
  input  logic [DATA_32_W-1:0] md_rs,
  input  logic [DATA_32_W-1:0] md_rt,
  output logic                 md_busy,
  output logic [DATA_32_W-1:0] reg_file_mult_data_low,
  output logic [DATA_32_W-1:0] reg_file_mult_data_high,
`ifdef MULT_DIV_DIV0_FLAG_EN
  output logic                 md_div_zero,
`endif
  output logic                 reg_file_mult_write
);

  localparam int unsigned W = DATA_32_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_div_q;
  logic               sign_res_q;
  logic               sign_rem_q;
  logic               div0_q;
  logic [W-1:0]       opnd_q;
  logic [ACC_W-1:0]   acc_q;
  logic [W-1:0]       rem_q;

  logic               is_signed_c;
  logic [W-1:0]       mag_rs_c;
  logic [W-1:0]       mag_rt_c;
  logic               div0_fast_c;
  logic [W:0]         add_c;
  logic [W:0]         shift_c;
  logic               qbit_c;
  logic [W-1:0]       rem_next_c;
  logic [ACC_W-1:0]   prod_fix_c;
  logic [W-1:0]       fix_lo_c;
  logic [W-1:0]       fix_hi_c;

  // Operand magnitudes for the unsigned core
  always_comb begin
    is_signed_c = ~md_op[0];
    mag_rs_c    = (is_signed_c && md_rs[W-1]) ? (~md_rs + W'(1)) : md_rs;
    mag_rt_c    = (is_signed_c && md_rt[W-1]) ? (~md_rt + W'(1)) : md_rt;
  end

`ifdef MULT_DIV_DIV0_FLAG_EN
  assign div0_fast_c = (state_q == S_IDLE) && md_start && md_op[1] && (md_rt == '0);
`else
  assign div0_fast_c = 1'b0;
`endif

  // One radix-2 multiply step and one restoring divide step
  always_comb begin
    add_c      = {1'b0, acc_q[ACC_W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    shift_c    = {rem_q, acc_q[W-1]};
    qbit_c     = (shift_c >= {1'b0, opnd_q});
    rem_next_c = qbit_c ? W'(shift_c - {1'b0, opnd_q}) : W'(shift_c);
  end

  // Sign fixup. On divide-by-zero the core leaves |rs| as remainder, so the
  // dividend-sign negation reproduces md_rs exactly; only LO is forced.
  always_comb begin
    prod_fix_c = sign_res_q ? (~acc_q + ACC_W'(1)) : acc_q;
    fix_lo_c   = prod_fix_c[W-1:0];
    fix_hi_c   = prod_fix_c[ACC_W-1:W];
    if (op_div_q) begin
      fix_lo_c = div0_q     ? {W{1'b1}} :
                 sign_res_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
      fix_hi_c = sign_rem_q ? (~rem_q + W'(1)) : rem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (md_start) state_d = div0_fast_c ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand latch in IDLE, one iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      div0_q     <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_start) begin
            op_div_q   <= md_op[1];
            sign_res_q <= is_signed_c & (md_rs[W-1] ^ md_rt[W-1]);
            sign_rem_q <= (md_op == OP_DIV) & md_rs[W-1];
            div0_q     <= md_op[1] & (md_rt == '0);
            opnd_q     <= md_op[1] ? mag_rt_c : mag_rs_c;
            acc_q      <= {W'(0), (md_op[1] ? mag_rs_c : mag_rt_c)};
            rem_q      <= '0;
            cnt_q      <= CNT_W'(W - 1);
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_div_q) begin
            acc_q[W-1:0] <= {acc_q[W-2:0], qbit_c};
            rem_q        <= rem_next_c;
          end else begin
            acc_q <= {add_c, acc_q[W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; data changes only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_busy                 <= 1'b0;
      reg_file_mult_write     <= 1'b0;
      reg_file_mult_data_low  <= '0;
      reg_file_mult_data_high <= '0;
`ifdef MULT_DIV_DIV0_FLAG_EN
      md_div_zero             <= 1'b0;
`endif
    end else begin
      md_busy             <= (state_d != S_IDLE);
      reg_file_mult_write <= (state_d == S_DONE);
      if (state_q == S_FIX) begin
        reg_file_mult_data_low  <= fix_lo_c;
        reg_file_mult_data_high <= fix_hi_c;
      end
`ifdef MULT_DIV_DIV0_FLAG_EN
      md_div_zero <= div0_fast_c;
      if (div0_fast_c) begin
        reg_file_mult_data_low  <= {W{1'b1}};
        reg_file_mult_data_high <= md_rs;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a 64-bit arithmetic model.
// Honours MULT_DIV_DIV0_FLAG_EN for the divide-by-zero fast path.

module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk;
  logic        rst;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_rs;
  logic [31:0] md_rt;
  logic        md_busy;
  logic [31:0] reg_file_mult_data_low;
  logic [31:0] reg_file_mult_data_high;
  logic        reg_file_mult_write;
`ifdef MULT_DIV_DIV0_FLAG_EN
  logic        md_div_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .md_start                (md_start),
    .md_op                   (md_op),
    .md_rs                   (md_rs),
    .md_rt                   (md_rt),
    .md_busy                 (md_busy),
    .reg_file_mult_data_low  (reg_file_mult_data_low),
    .reg_file_mult_data_high (reg_file_mult_data_high),
`ifdef MULT_DIV_DIV0_FLAG_EN
    .md_div_zero             (md_div_zero),
`endif
    .reg_file_mult_write     (reg_file_mult_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {HI, LO} straight from MIPS arithmetic semantics
  function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint sr, st, q, m;
    logic [63:0] r;
    sr = longint'($signed(rs));
    st = longint'($signed(rt));
    r  = '0;
    case (op)
      2'b00: r = 64'(sr * st);
      2'b01: r = {32'h0, rs} * {32'h0, rt};
      2'b10: begin
        if (rt == 32'h0) r = {rs, 32'hFFFF_FFFF};
        else begin
          q = sr / st;
          m = sr % st;
          r = {32'(m), 32'(q)};
        end
      end
      default: begin
        if (rt == 32'h0) r = {rs, 32'hFFFF_FFFF};
        else             r = {rs % rt, rs / rt};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op in the current cycle (cycle 0) and follow it to one cycle past DONE
  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, input bit pulses);
    logic [63:0] exp;
    int          exp_lat, lat, n_strobe, busy_bad;
    logic [31:0] lo_s, hi_s;
    logic        dz_s, dz_exp;
    bit          fast;
    exp    = ref_hilo(op, rs, rt);
    fast   = 1'b0;
    dz_s   = 1'b0;
`ifdef MULT_DIV_DIV0_FLAG_EN
    fast   = op[1] && (rt == 32'h0);
`endif
    dz_exp  = fast;
    exp_lat = fast ? 1 : DATA_32_W + 2;
    md_op = op; md_rs = rs; md_rt = rt; md_start = 1'b1;
    lat = 0; n_strobe = 0; busy_bad = 0; lo_s = '0; hi_s = '0;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        md_start = 1'b0; md_rs = $urandom; md_rt = $urandom; md_op = 2'($urandom);
      end
      if (pulses && (k == 5 || k == 20)) md_start = 1'b1;
      if (pulses && (k == 6 || k == 21)) md_start = 1'b0;
      if (md_busy !== 1'(k <= exp_lat)) busy_bad++;
      if (reg_file_mult_write) begin
        n_strobe++;
        lat  = k;
        lo_s = reg_file_mult_data_low;
        hi_s = reg_file_mult_data_high;
`ifdef MULT_DIV_DIV0_FLAG_EN
        dz_s = md_div_zero;
`endif
      end
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("strobes", 64'(n_strobe), 64'd1);
    check_eq("lo", 64'(lo_s), 64'(exp[31:0]));
    check_eq("hi", 64'(hi_s), 64'(exp[63:32]));
    check_eq("busy", 64'(busy_bad), 64'd0);
    check_eq("hold", {reg_file_mult_data_high, reg_file_mult_data_low}, exp);
`ifdef MULT_DIV_DIV0_FLAG_EN
    check_eq("div_zero", 64'(dz_s), 64'(dz_exp));
`else
    if (dz_s != dz_exp) check_eq("div_zero", 64'(dz_s), 64'(dz_exp));
`endif
  endtask

  task automatic reset_mid_op();
    int n_strobe;
    md_op = 2'b00; md_rs = 32'h1234_5678; md_rt = 32'h0000_0ABC; md_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) md_start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_busy", 64'(md_busy), 64'd0);
    check_eq("rst_out", {reg_file_mult_data_high, reg_file_mult_data_low}, 64'd0);
    check_eq("rst_write", 64'(reg_file_mult_write), 64'd0);
    rst = 1'b0;
    n_strobe = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (reg_file_mult_write) n_strobe++;
    end
    check_eq("rst_nostrobe", 64'(n_strobe), 64'd0);
  endtask

  initial begin
    rst = 1'b1; md_start = 1'b0; md_op = 2'b00; md_rs = '0; md_rt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", 64'(md_busy), 64'd0);
    check_eq("reset_out", {reg_file_mult_data_high, reg_file_mult_data_low}, 64'd0);
    check_eq("reset_write", 64'(reg_file_mult_write), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF6, 32'd0, 1'b0);
    run_op(2'b00, 32'd123, 32'hFFFF_FF00, 1'b1);
    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b0);

    reset_mid_op();
    run_op(2'b01, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick_val(), pick_val(), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
